j_pit_dncnt: RTL and testbench
==============================

Name: j_pit_dncnt

Overview:
Loadable two-stage down-counting interval timer for the Jerry DSP interrupt logic. It is the consumer-side counterpart to the small enabled up-counters used there: it counts down from programmed reload values rather than up from zero. A 16-bit prescaler decrements on enabled clocks. Each prescaler underflow decrements a 16-bit divider, and each divider underflow produces a one-cycle tick and sets a sticky interrupt request. The block sits between the DSP register decode (writes, enable) and the interrupt latch (irq, irq_clr).

Parameters:
PW, 16, prescaler counter/reload width in bits
DW, 16, divider counter/reload width in bits

Ports:
clk  in  1  sole clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  count enable; 0 freezes both counters
pre_wr  in  1  one-cycle strobe: load prescaler reload and counter from wdata[PW-1:0]
div_wr  in  1  one-cycle strobe: load divider reload and counter from wdata[DW-1:0]
wdata  in  16  write data (shared by pre_wr and div_wr)
irq_clr  in  1  clear sticky irq
pre_cnt  out  PW  current prescaler count
div_cnt  out  DW  current divider count
tick  out  1  registered one-cycle pulse, high the cycle after a divider underflow
irq  out  1  sticky interrupt request

Behaviour:
- Reset (asynchronous, active-high): pre_cnt=0, div_cnt=0, pre_rld=0, div_rld=0, tick=0, irq=0; oneshot stopped flag (if compiled in)=0. Reset takes effect at any time, including mid-count.
- pre_wr: pre_rld<=wdata and pre_cnt<=wdata. div_wr: the same for div_rld/div_cnt. Both strobes may occur in one cycle; each loads its own counter.
- Counting step, taken on a cycle with en=1 and no write to the affected counter:
  - Prescaler: if pre_cnt==0 then pre_cnt<=pre_rld and a divider step is issued; else pre_cnt<=pre_cnt-1.
  - Divider step: if div_cnt==0 then div_cnt<=div_rld and underflow=1; else div_cnt<=div_cnt-1.
- Tick period = (pre_rld+1)*(div_rld+1) enabled cycles. Arithmetic is unsigned modulo 2^W; no value wraps below 0 other than through reload.
- tick is registered: tick<=underflow, so it is high exactly one cycle after the underflow edge and 0 otherwise. If reload=0/0, tick stays high continuously while en=1.
- irq: set when underflow=1 (same edge that sets tick); cleared by irq_clr. If both happen on the same edge, set wins.
- Collision rules:
  - pre_wr in the same cycle as a prescaler underflow: the write wins and no divider step is issued.
  - div_wr in the same cycle as a divider step: the write wins, with no underflow and no tick.
  - A write with en=0 loads normally.
- en=0: both counters hold, no underflow, and tick is 0 on the following cycle. Counting resumes from the held values when en returns to 1.
- Reload values are never modified by counting; only writes and reset change them.

Optional Feature:
Macro J_PIT_ONESHOT_EN.
- Defined:
  - Extra input port oneshot (1 bit).
  - When oneshot=1 and a divider underflow occurs, the internal stopped flag is set. While stopped, both counters hold as though en=0. The counters still reload on the underflow edge.
  - Any div_wr clears stopped.
  - tick and irq behave as normal for the single underflow.
- Undefined: the oneshot port and stopped flag are absent, and the timer is always periodic.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle with nonzero counts -> pre_cnt=0, div_cnt=0, tick=0, irq=0 immediately, with no clock edge needed.
- Periodic: pre_wr 1, div_wr 2, then en=1 for 20 cycles -> tick high on enabled cycle 7, then again on cycles 13 and 19 (period 6); irq=1 from cycle 7.
- Minimum period: pre_wr 0, div_wr 0, en=1 -> tick high every cycle from the second enabled cycle onward; div_cnt stays 0.
- irq race: with pre=0, div=1, pulse irq_clr on the underflow edge -> irq remains 1. Pulse irq_clr on a non-underflow cycle -> irq=0.
- Freeze and collision:
  - pre=3, div=1: drop en after 2 cycles, hold for 5 -> pre_cnt stays at 1 and tick stays 0; resume -> next tick arrives on schedule.
  - Issue div_wr 5 on an underflow cycle -> no tick, div_cnt=5.
- J_PIT_ONESHOT_EN build: oneshot=1, pre=0, div=2 -> exactly one tick (enabled cycle 4), counters then frozen; div_wr 2 restarts -> one more tick.

Source files
------------

// File: rtl/j_pit_dncnt.sv
// Loadable two-stage down-counting interval timer: a prescaler feeding a divider, with a tick pulse and a sticky irq.
// Optional one-shot mode: define J_PIT_ONESHOT_EN to add the oneshot input and the stopped flag.
module j_pit_dncnt #(
    parameter int PW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          pre_wr,
    input  logic          div_wr,
    input  logic [15:0]   wdata,
    input  logic          irq_clr,
`ifdef J_PIT_ONESHOT_EN
    input  logic          oneshot,
`endif
    output logic [PW-1:0] pre_cnt,
    output logic [DW-1:0] div_cnt,
    output logic          tick,
    output logic          irq
);

    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [PW-1:0] pre_rld_q, pre_rld_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [DW-1:0] div_rld_q, div_rld_d;
    logic          tick_q, tick_d;
    logic          irq_q, irq_d;
    logic          run;
    logic          div_step;
    logic          underflow;

`ifdef J_PIT_ONESHOT_EN
    logic stopped_q, stopped_d;

    assign run = en && !stopped_q;
`else
    assign run = en;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves a latch behind.
        pre_cnt_d = pre_cnt_q;
        pre_rld_d = pre_rld_q;
        div_cnt_d = div_cnt_q;
        div_rld_d = div_rld_q;
        div_step  = 1'b0;
        underflow = 1'b0;

        // A write always beats the counting step of its own stage.
        if (pre_wr) begin
            pre_rld_d = wdata[PW-1:0];
            pre_cnt_d = wdata[PW-1:0];
        end else if (run) begin
            if (pre_cnt_q == '0) begin
                pre_cnt_d = pre_rld_q;
                div_step  = 1'b1;
            end else begin
                pre_cnt_d = pre_cnt_q - PW'(1);
            end
        end

        if (div_wr) begin
            div_rld_d = wdata[DW-1:0];
            div_cnt_d = wdata[DW-1:0];
        end else if (div_step) begin
            if (div_cnt_q == '0) begin
                div_cnt_d = div_rld_q;
                underflow = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q - DW'(1);
            end
        end

        tick_d = underflow;
        irq_d  = underflow || (irq_q && !irq_clr);
    end

`ifdef J_PIT_ONESHOT_EN
    always_comb begin
        stopped_d = stopped_q;
        if (div_wr)
            stopped_d = 1'b0;
        else if (underflow && oneshot)
            stopped_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stopped_q <= 1'b0;
        else       stopped_q <= stopped_d;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt_q <= '0;
            pre_rld_q <= '0;
            div_cnt_q <= '0;
            div_rld_q <= '0;
            tick_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pre_rld_q <= pre_rld_d;
            div_cnt_q <= div_cnt_d;
            div_rld_q <= div_rld_d;
            tick_q    <= tick_d;
            irq_q     <= irq_d;
        end
    end

    assign pre_cnt = pre_cnt_q;
    assign div_cnt = div_cnt_q;
    assign tick    = tick_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_j_pit_dncnt.sv
// Directed self-checking bench for j_pit_dncnt; expected tick/irq values are queued per cycle and popped after each edge.
module tb_j_pit_dncnt;
    localparam int PW = 16;
    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic          en;
    logic          pre_wr;
    logic          div_wr;
    logic [15:0]   wdata;
    logic          irq_clr;
    logic [PW-1:0] pre_cnt;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          irq;
`ifdef J_PIT_ONESHOT_EN
    logic          oneshot;
`endif

    typedef struct {
        string tag;
        logic  tick;
        logic  irq;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    j_pit_dncnt #(.PW(PW), .DW(DW)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .pre_wr  (pre_wr),
        .div_wr  (div_wr),
        .wdata   (wdata),
        .irq_clr (irq_clr),
`ifdef J_PIT_ONESHOT_EN
        .oneshot (oneshot),
`endif
        .pre_cnt (pre_cnt),
        .div_cnt (div_cnt),
        .tick    (tick),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic t, input logic i);
        exp_t e;
        e.tag  = tag;
        e.tick = t;
        e.irq  = i;
        sb.push_back(e);
    endtask

    // One clock: queue the expectation for this edge, advance, then pop and compare.
    task automatic step(input string tag, input logic t, input logic i);
        exp_t e;
        expect_out(tag, t, i);
        cyc();
        e = sb.pop_front();
        check({e.tag, "_tick"}, {31'b0, tick}, {31'b0, e.tick});
        check({e.tag, "_irq"},  {31'b0, irq},  {31'b0, e.irq});
    endtask

    task automatic write_pre(input logic [15:0] v);
        pre_wr = 1'b1;
        wdata  = v;
        cyc();
        pre_wr = 1'b0;
    endtask

    task automatic write_div(input logic [15:0] v);
        div_wr = 1'b1;
        wdata  = v;
        cyc();
        div_wr = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        en      = 1'b0;
        pre_wr  = 1'b0;
        div_wr  = 1'b0;
        wdata   = '0;
        irq_clr = 1'b0;
`ifdef J_PIT_ONESHOT_EN
        oneshot = 1'b0;
`endif
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        check("rst_pre", 32'(pre_cnt), 32'd0);
        check("rst_div", 32'(div_cnt), 32'd0);
        check("rst_tick", {31'b0, tick}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);

        // Periodic: pre=1, div=2 gives period 6.
        write_pre(16'd1);
        write_div(16'd2);
        check("load_pre", 32'(pre_cnt), 32'd1);
        check("load_div", 32'(div_cnt), 32'd2);
        en = 1'b1;
        for (int n = 1; n <= 20; n++)
            step($sformatf("per%0d", n), (n % 6) == 0, n >= 6);
        check("mid_pre", 32'(pre_cnt), 32'd1);
        check("mid_div", 32'(div_cnt), 32'd1);

        // Asynchronous reset between edges.
        #2 reset = 1'b1;
        #1;
        check("arst_pre", 32'(pre_cnt), 32'd0);
        check("arst_div", 32'(div_cnt), 32'd0);
        check("arst_tick", {31'b0, tick}, 32'd0);
        check("arst_irq", {31'b0, irq}, 32'd0);
        #1 reset = 1'b0;
        en = 1'b0;

        // Minimum period: reload 0/0 ticks on every enabled edge.
        write_pre(16'd0);
        write_div(16'd0);
        en = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step($sformatf("min%0d", n), 1'b1, 1'b1);
            check($sformatf("min%0d_div", n), 32'(div_cnt), 32'd0);
        end
        en = 1'b0;
        step("min_off", 1'b0, 1'b1);

        // irq race: clear on underflow edge loses, clear on quiet edge wins.
        irq_clr = 1'b1;
        step("clr0", 1'b0, 1'b0);
        irq_clr = 1'b0;
        write_div(16'd1);
        en = 1'b1;
        step("race1", 1'b0, 1'b0);
        irq_clr = 1'b1;
        step("race2", 1'b1, 1'b1);
        step("race3", 1'b0, 1'b0);
        irq_clr = 1'b0;
        en = 1'b0;

        // Freeze: pre=3, div=1 -> period 8; hold after 2 enabled edges.
        write_pre(16'd3);
        write_div(16'd1);
        en = 1'b1;
        step("frz1", 1'b0, 1'b0);
        step("frz2", 1'b0, 1'b0);
        en = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            step($sformatf("hold%0d", n), 1'b0, 1'b0);
            check($sformatf("hold%0d_pre", n), 32'(pre_cnt), 32'd1);
        end
        en = 1'b1;
        for (int n = 3; n <= 15; n++)
            step($sformatf("res%0d", n), n == 8, n >= 8);

        // div_wr on the underflow edge wins: no tick, divider loaded.
        div_wr = 1'b1;
        wdata  = 16'd5;
        step("coll", 1'b0, 1'b1);
        div_wr = 1'b0;
        check("coll_div", 32'(div_cnt), 32'd5);
        check("coll_pre", 32'(pre_cnt), 32'd3);
        step("coll_next", 1'b0, 1'b1);
        check("coll_next_div", 32'(div_cnt), 32'd5);
        en = 1'b0;

`ifdef J_PIT_ONESHOT_EN
        // One-shot: pre=0, div=2 gives a single tick, then frozen until div_wr.
        oneshot = 1'b1;
        irq_clr = 1'b1;
        step("os_clr", 1'b0, 1'b0);
        irq_clr = 1'b0;
        write_pre(16'd0);
        write_div(16'd2);
        en = 1'b1;
        for (int n = 1; n <= 8; n++)
            step($sformatf("os%0d", n), n == 3, n >= 3);
        check("os_pre", 32'(pre_cnt), 32'd0);
        check("os_div", 32'(div_cnt), 32'd2);
        en = 1'b0;
        write_div(16'd2);
        en = 1'b1;
        for (int n = 1; n <= 6; n++)
            step($sformatf("os_re%0d", n), n == 3, 1'b1);
        en = 1'b0;
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
